// File: rtl/axis_loop_buf.sv
// AXI-Stream loopback buffer: S beats are queued in a DEPTH-entry FIFO and replayed on M,
// or discarded whole-packet when drop mode is selected at a packet boundary.
module axis_loop_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1
) (
    input  logic                     aclk_0,
    input  logic                     areset_0,
    input  logic [DATA_W-1:0]        S_AXIS_0_tdata,
    input  logic [DATA_W/8-1:0]      S_AXIS_0_tstrb,
    input  logic [ID_W-1:0]          S_AXIS_0_tid,
    input  logic [DEST_W-1:0]        S_AXIS_0_tdest,
    input  logic                     S_AXIS_0_tlast,
    input  logic                     S_AXIS_0_tvalid,
    output logic                     S_AXIS_0_tready,
    output logic [DATA_W-1:0]        M_AXIS_0_tdata,
    output logic [DATA_W/8-1:0]      M_AXIS_0_tstrb,
    output logic [ID_W-1:0]          M_AXIS_0_tid,
    output logic [DEST_W-1:0]        M_AXIS_0_tdest,
    output logic                     M_AXIS_0_tlast,
    output logic                     M_AXIS_0_tvalid,
    input  logic                     M_AXIS_0_tready,
    input  logic                     drop_en,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              pkt_cnt,
    output logic [31:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = DATA_W / 8;
    localparam int EW = DATA_W + SW + ID_W + DEST_W + 1;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          in_pkt;
    logic          drop_q;
    logic          drop_eff;
    logic          full;
    logic          empty;
    logic          s_hs;
    logic          m_hs;
    logic          push;
    logic          pop;

    assign full     = (occupancy == FULL_LVL);
    assign empty    = (occupancy == '0);
    // Mode is frozen for the whole packet once its first beat has been accepted
    assign drop_eff = in_pkt ? drop_q : drop_en;

    assign S_AXIS_0_tready = !areset_0 && (drop_eff || !full);
    assign M_AXIS_0_tvalid = !areset_0 && !empty;

    assign s_hs = S_AXIS_0_tvalid && S_AXIS_0_tready;
    assign m_hs = M_AXIS_0_tvalid && M_AXIS_0_tready;
    assign push = s_hs && !drop_eff;
    assign pop  = m_hs;

    assign head = mem[rd_ptr];
    assign {M_AXIS_0_tdata, M_AXIS_0_tstrb, M_AXIS_0_tid, M_AXIS_0_tdest, M_AXIS_0_tlast} = head;

    always_ff @(posedge aclk_0) begin
        if (push) begin
            mem[wr_ptr] <= {S_AXIS_0_tdata, S_AXIS_0_tstrb, S_AXIS_0_tid,
                            S_AXIS_0_tdest, S_AXIS_0_tlast};
        end
    end

    always_ff @(posedge aclk_0) begin
        if (areset_0) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            in_pkt    <= 1'b0;
            drop_q    <= 1'b0;
            pkt_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + (AW+1)'(1);
                2'b01:   occupancy <= occupancy - (AW+1)'(1);
                default: occupancy <= occupancy;
            endcase
            if (s_hs) begin
                in_pkt <= !S_AXIS_0_tlast;
            end
            if (!in_pkt) begin
                drop_q <= drop_en;
            end
            if (pop && M_AXIS_0_tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (s_hs && drop_eff && S_AXIS_0_tlast) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_loop_buf.sv
// Directed bench for axis_loop_buf: a queue-based packet model checked every cycle,
// plus literal expectations for the loop, backpressure, streaming, drop, reset and wrap cases.
module tb_axis_loop_buf;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ID_W   = 1;
    localparam int DEST_W = 1;
    localparam int SW     = DATA_W / 8;
    localparam int EW     = DATA_W + SW + ID_W + DEST_W + 1;

    logic                   aclk_0   = 1'b0;
    logic                   areset_0 = 1'b1;
    logic [DATA_W-1:0]      s_tdata  = '0;
    logic [SW-1:0]          s_tstrb  = '0;
    logic [ID_W-1:0]        s_tid    = '0;
    logic [DEST_W-1:0]      s_tdest  = '0;
    logic                   s_tlast  = 1'b0;
    logic                   s_tvalid = 1'b0;
    logic                   s_tready;
    logic [DATA_W-1:0]      m_tdata;
    logic [SW-1:0]          m_tstrb;
    logic [ID_W-1:0]        m_tid;
    logic [DEST_W-1:0]      m_tdest;
    logic                   m_tlast;
    logic                   m_tvalid;
    logic                   m_tready = 1'b0;
    logic                   drop_en  = 1'b0;
    logic [$clog2(DEPTH):0] occupancy;
    logic [31:0]            pkt_cnt;
    logic [31:0]            drop_cnt;

    axis_loop_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ID_W(ID_W), .DEST_W(DEST_W)) dut (
        .aclk_0          (aclk_0),
        .areset_0        (areset_0),
        .S_AXIS_0_tdata  (s_tdata),
        .S_AXIS_0_tstrb  (s_tstrb),
        .S_AXIS_0_tid    (s_tid),
        .S_AXIS_0_tdest  (s_tdest),
        .S_AXIS_0_tlast  (s_tlast),
        .S_AXIS_0_tvalid (s_tvalid),
        .S_AXIS_0_tready (s_tready),
        .M_AXIS_0_tdata  (m_tdata),
        .M_AXIS_0_tstrb  (m_tstrb),
        .M_AXIS_0_tid    (m_tid),
        .M_AXIS_0_tdest  (m_tdest),
        .M_AXIS_0_tlast  (m_tlast),
        .M_AXIS_0_tvalid (m_tvalid),
        .M_AXIS_0_tready (m_tready),
        .drop_en         (drop_en),
        .occupancy       (occupancy),
        .pkt_cnt         (pkt_cnt),
        .drop_cnt        (drop_cnt)
    );

    always #5 aclk_0 = ~aclk_0;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en  = 1'b0;
    bit preload = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: queue of looped beats, packet mode chosen at the first beat
    logic [EW-1:0] mq[$];
    int unsigned   m_pkt    = 0;
    int unsigned   m_drop   = 0;
    bit            m_in_pkt = 1'b0;
    bit            m_mode   = 1'b0;

    function automatic bit mdl_drop();
        return m_in_pkt ? m_mode : drop_en;
    endfunction

    function automatic bit mdl_s_ready();
        return !areset_0 && (mdl_drop() || mq.size() < DEPTH);
    endfunction

    always @(posedge aclk_0) begin
        bit            s_hs;
        bit            d;
        logic [EW-1:0] e;
        if (areset_0) begin
            mq.delete();
            m_pkt    = 0;
            m_drop   = 0;
            m_in_pkt = 1'b0;
            m_mode   = 1'b0;
        end else begin
            s_hs = s_tvalid && mdl_s_ready();
            d    = mdl_drop();
            if (m_tready && mq.size() != 0) begin
                e = mq.pop_front();
                if (e[0]) m_pkt++;
            end
            if (preload) m_pkt = 32'hFFFF_FFFF;
            if (s_hs) begin
                if (!d) mq.push_back({s_tdata, s_tstrb, s_tid, s_tdest, s_tlast});
                if (s_tlast && d) m_drop++;
                m_in_pkt = !s_tlast;
                m_mode   = d;
            end
        end
    end

    always @(negedge aclk_0) begin
        bit mv;
        if (chk_en) begin
            mv = !areset_0 && mq.size() != 0;
            chk("s_tready", 64'(s_tready), 64'(mdl_s_ready()));
            chk("m_tvalid", 64'(m_tvalid), 64'(mv));
            if (mv) chk("m_payload", 64'({m_tdata, m_tstrb, m_tid, m_tdest, m_tlast}), 64'(mq[0]));
            chk("occupancy", 64'(occupancy), 64'(mq.size()));
            if (!preload) chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        end
    end

    // Cycle numbers of observed M handshakes (sampled while inputs and outputs are stable)
    int cyc = 0;
    int hs_cyc[$];
    always @(negedge aclk_0) begin
        cyc++;
        if (!areset_0 && m_tvalid && m_tready) hs_cyc.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk_0);
            #1;
        end
    endtask

    task automatic do_reset();
        areset_0 = 1'b1;
        tick(1);
        areset_0 = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic last);
        bit ok;
        ok       = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tstrb  = d[7:4];
        s_tid    = d[8];
        s_tdest  = d[9];
        s_tlast  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk_0);
            ok = s_tready;
            @(posedge aclk_0);
            #1;
            if (ok) break;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk_0);
            if (occupancy == 0 && !m_tvalid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge aclk_0);
        #1;
    endtask

    initial begin
        int base;
        tick(2);
        areset_0 = 1'b0;
        chk_en   = 1'b1;
        @(negedge aclk_0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_pkt", 64'(pkt_cnt), 64'd0);
        tick(1);

        // Single-beat loop
        m_tready = 1'b1;
        drive_beat(32'hA5A5_A5A5, 1'b1);
        @(negedge aclk_0);
        chk("loop_valid", 64'(m_tvalid), 64'd1);
        chk("loop_data", 64'(m_tdata), 64'hA5A5_A5A5);
        tick(1);
        @(negedge aclk_0);
        chk("loop_pkt", 64'(pkt_cnt), 64'd1);
        chk("loop_occ", 64'(occupancy), 64'd0);
        tick(1);

        // Fill and backpressure
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) drive_beat(32'h100 + i, (i == DEPTH - 1));
        @(negedge aclk_0);
        chk("fill_occ", 64'(occupancy), 64'd16);
        chk("fill_ready", 64'(s_tready), 64'd0);
        chk("fill_head", 64'(m_tdata), 64'h100);
        tick(1);
        m_tready = 1'b1;
        @(negedge aclk_0);
        chk("full_no_bypass", 64'(s_tready), 64'd0);
        tick(1);
        m_tready = 1'b0;
        @(negedge aclk_0);
        chk("pop_ready", 64'(s_tready), 64'd1);
        chk("pop_occ", 64'(occupancy), 64'd15);
        chk("pop_head", 64'(m_tdata), 64'h101);
        tick(1);
        m_tready = 1'b1;
        wait_empty();
        @(negedge aclk_0);
        chk("fill_pkt", 64'(pkt_cnt), 64'd1);
        tick(1);

        // Streaming: 100-beat packet at one beat per cycle
        do_reset();
        base = hs_cyc.size();
        for (int i = 0; i < 100; i++) drive_beat(32'(i * 7), (i == 99));
        wait_empty();
        chk("stream_beats", 64'(hs_cyc.size() - base), 64'd100);
        if (hs_cyc.size() - base == 100)
            chk("stream_span", 64'(hs_cyc[base + 99] - hs_cyc[base]), 64'd99);
        @(negedge aclk_0);
        chk("stream_pkt", 64'(pkt_cnt), 64'd1);
        tick(1);

        // Mode change mid-packet, then a dropped packet
        do_reset();
        base = hs_cyc.size();
        drive_beat(32'h2001, 1'b0);
        drive_beat(32'h2002, 1'b0);
        drop_en = 1'b1;
        drive_beat(32'h2003, 1'b0);
        drive_beat(32'h2004, 1'b1);
        drive_beat(32'h3001, 1'b0);
        drive_beat(32'h3002, 1'b0);
        drive_beat(32'h3003, 1'b1);
        wait_empty();
        chk("mode_beats", 64'(hs_cyc.size() - base), 64'd4);
        @(negedge aclk_0);
        chk("mode_pkt", 64'(pkt_cnt), 64'd1);
        chk("mode_drop", 64'(drop_cnt), 64'd1);
        tick(1);
        drop_en = 1'b0;

        // Reset in the middle of a buffered packet
        do_reset();
        drive_beat(32'h4001, 1'b1);
        drop_en = 1'b1;
        drive_beat(32'h4002, 1'b1);
        drop_en  = 1'b0;
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) drive_beat(32'h5000 + i, 1'b0);
        @(negedge aclk_0);
        chk("mid_occ", 64'(occupancy), 64'd5);
        chk("mid_pkt", 64'(pkt_cnt), 64'd1);
        chk("mid_drop", 64'(drop_cnt), 64'd1);
        tick(1);
        areset_0 = 1'b1;
        @(negedge aclk_0);
        chk("inrst_valid", 64'(m_tvalid), 64'd0);
        chk("inrst_ready", 64'(s_tready), 64'd0);
        tick(1);
        areset_0 = 1'b0;
        @(negedge aclk_0);
        chk("postrst_valid", 64'(m_tvalid), 64'd0);
        chk("postrst_occ", 64'(occupancy), 64'd0);
        chk("postrst_pkt", 64'(pkt_cnt), 64'd0);
        chk("postrst_drop", 64'(drop_cnt), 64'd0);
        tick(1);
        m_tready = 1'b1;
        drive_beat(32'hBEEF_0001, 1'b0);
        drive_beat(32'hBEEF_0002, 1'b1);
        wait_empty();
        @(negedge aclk_0);
        chk("postrst_newpkt", 64'(pkt_cnt), 64'd1);
        tick(1);

        // pkt_cnt wrap
        do_reset();
        force dut.pkt_cnt = 32'hFFFF_FFFF;
        preload = 1'b1;
        tick(1);
        release dut.pkt_cnt;
        preload = 1'b0;
        @(negedge aclk_0);
        chk("wrap_pre", 64'(pkt_cnt), 64'hFFFF_FFFF);
        tick(1);
        drive_beat(32'h1234_5678, 1'b1);
        wait_empty();
        @(negedge aclk_0);
        chk("wrap_pkt", 64'(pkt_cnt), 64'd0);
        tick(1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
